// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch widths, reset PC, PC step and the {instr, pc} packet.
// The occupancy encoding of the fetch output register pair also lives here.
package cpu_pkg;
   localparam int          INSTR_W  = 32;
   localparam int          ADDR_W   = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_pkt_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus 1-entry skid for fetch packets; a landing packet is visible the next cycle.
// Never drops a packet while out_rdy is low; the producer must stop issuing once occupancy is TWO.
module fetch_skid_buf
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       in_vld,
   input  fetch_pkt_t in_dat,
   input  logic       out_rdy,
   output logic       out_vld,
   output fetch_pkt_t out_dat,
   output occ_e       occ
);

   fetch_pkt_t skid_dat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ      <= OCC_EMPTY;
         out_vld  <= 1'b0;
         out_dat  <= '0;
         skid_dat <= '0;
      end else if (flush) begin
         occ     <= OCC_EMPTY;
         out_vld <= 1'b0;
      end else begin
         case (occ)
            OCC_EMPTY: begin
               if (in_vld) begin
                  out_dat <= in_dat;
                  out_vld <= 1'b1;
                  occ     <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               // out_vld is high here, so out_rdy alone means a handshake
               if (in_vld && out_rdy) begin
                  out_dat <= in_dat;
               end else if (in_vld) begin
                  skid_dat <= in_dat;
                  occ      <= OCC_TWO;
               end else if (out_rdy) begin
                  out_vld <= 1'b0;
                  occ     <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (out_rdy) begin
                  out_dat <= skid_dat;
                  occ     <= OCC_ONE;
               end
            end
            default: begin
               occ     <= OCC_EMPTY;
               out_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, ROM issue and redirect flush ahead of a skid-buffered {instr, pc} output.
// ROM data lands 1 cycle after issue; issue stalls under backpressure. IFETCH_PERF_CNT_EN adds fetch_count.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = cpu_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter int                INSTR_W  = cpu_pkg::INSTR_W
)(
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_count
`endif
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] issued_pc_q;
   logic              inflight_q;
   occ_e              occ;
   fetch_pkt_t        rsp_pkt;
   fetch_pkt_t        out_pkt;
   logic [1:0]        redirect_lsb_unused;

   assign redirect_lsb_unused = redirect_pc[1:0];

   // Stop issuing when the response could have nowhere to land next cycle.
   assign imem_req  = rst_n && !redirect_valid && (occ != OCC_TWO) &&
                      !((occ == OCC_ONE) && inflight_q && !instr_ready);
   assign imem_addr = pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= {RESET_PC[ADDR_W-1:2], 2'b00};
         issued_pc_q <= '0;
         inflight_q  <= 1'b0;
      end else if (redirect_valid) begin
         pc_q       <= {redirect_pc[ADDR_W-1:2], 2'b00};
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= imem_req;
         if (imem_req) begin
            pc_q        <= pc_q + ADDR_W'(PC_STEP);
            issued_pc_q <= pc_q;
         end
      end
   end

   assign rsp_pkt = '{instr: imem_rdata, pc: issued_pc_q};

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (redirect_valid),
      .in_vld  (inflight_q && !redirect_valid),
      .in_dat  (rsp_pkt),
      .out_rdy (instr_ready),
      .out_vld (instr_valid),
      .out_dat (out_pkt),
      .occ     (occ)
   );

   assign instr    = out_pkt.instr;
   assign instr_pc = out_pkt.pc;

`ifdef IFETCH_PERF_CNT_EN
   // Redirects do not clear this; a handshake in a redirect cycle still counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= 32'd0;
      end else if (instr_valid && instr_ready) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`else
   // Handshakes are not counted in this build.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random ready/redirect traffic
// checked against an in-order PC-stream reference model.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   int          checks = 0;
   int          errors = 0;

   // Reference model: decode must see consecutive words starting at the last redirect target.
   logic [31:0] exp_pc;
   logic [31:0] exp_fpc;
   logic [31:0] prev_instr;
   logic [31:0] prev_pc;
   logic        prev_stall;
   int          hs_cnt;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0000_0008) return 32'h01013b06;
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   // Synchronous ROM with 1-cycle latency; junk when not requested.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? rom(imem_addr) : 32'hBAD0_BAD0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
      logic [31:0] tgt;
      @(negedge clk);
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      tgt = {rpc[31:2], 2'b00};
`ifdef IFETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, 32'(hs_cnt));
`endif
      if (rv) chk("req_during_redirect", 32'(imem_req), 32'd0);
      if (imem_req) begin
         chk("imem_addr", imem_addr, exp_fpc);
         exp_fpc += 32'd4;
      end
      if (prev_stall) begin
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_instr", instr, prev_instr);
         chk("hold_pc", instr_pc, prev_pc);
      end
      if (instr_valid && rdy) begin
         chk("decode_pc", instr_pc, exp_pc);
         chk("decode_instr", instr, rom(exp_pc));
         exp_pc += 32'd4;
         hs_cnt++;
      end
      if (rv) begin
         exp_pc  = tgt;
         exp_fpc = tgt;
      end
      prev_stall = instr_valid && !rdy && !rv;
      prev_instr = instr;
      prev_pc    = instr_pc;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
      chk("rst_fetch_count", fetch_count, 32'd0);
`endif
      exp_pc     = 32'd0;
      exp_fpc    = 32'd0;
      prev_stall = 1'b0;
      hs_cnt     = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int hs0;
      rst_n          = 1'b1;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      #2;
      do_reset();

      // Streaming from reset with ready held high
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b0, 32'd0);
         if (i == 0) begin
            chk("t1_first_req", 32'(imem_req), 32'd1);
            chk("t1_first_addr", imem_addr, 32'd0);
         end
         if (i >= 2) chk("t1_stream_valid", 32'(instr_valid), 32'd1);
      end

      // Backpressure while pc 0x8 is presented
      do_reset();
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 32'd0);
         chk("t2_stall_pc", instr_pc, 32'h8);
         chk("t2_stall_instr", instr, 32'h01013b06);
         chk("t2_stall_req", 32'(imem_req), 32'd0);
      end
      tick(1'b1, 1'b0, 32'd0);
      chk("t2_release_pc0", instr_pc, 32'h8);
      tick(1'b1, 1'b0, 32'd0);
      chk("t2_release_valid1", 32'(instr_valid), 32'd1);
      chk("t2_release_pc1", instr_pc, 32'hC);

      // Redirect while both output and skid are full
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0);
      tick(1'b0, 1'b1, 32'h40);
      tick(1'b1, 1'b0, 32'd0);
      chk("t3_flushed_valid", 32'(instr_valid), 32'd0);
      chk("t3_target_req", 32'(imem_req), 32'd1);
      chk("t3_target_addr", imem_addr, 32'h40);
      for (int i = 0; i < 6 && !instr_valid; i++) tick(1'b1, 1'b0, 32'd0);
      chk("t3_target_valid", 32'(instr_valid), 32'd1);
      chk("t3_target_pc", instr_pc, 32'h40);

      // Misaligned redirect and address wrap
      tick(1'b1, 1'b1, 32'h43);
      tick(1'b1, 1'b0, 32'd0);
      chk("t4_aligned_addr", imem_addr, 32'h40);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'd0);
      tick(1'b1, 1'b1, 32'hFFFF_FFFC);
      tick(1'b1, 1'b0, 32'd0);
      chk("t4_top_addr", imem_addr, 32'hFFFF_FFFC);
      tick(1'b1, 1'b0, 32'd0);
      chk("t4_wrap_addr", imem_addr, 32'h0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'd0);

      // Asynchronous reset with the skid full, then restart
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0);
      do_reset();
      tick(1'b1, 1'b0, 32'd0);
      chk("t5_restart_addr", imem_addr, 32'h0);

      // Ten handshakes with a redirect in between
      do_reset();
      for (int i = 0; i < 40 && hs_cnt < 10; i++) tick(1'b1, i == 5, 32'h200);
      chk("t6_handshakes", 32'(hs_cnt), 32'd10);
      tick(1'b0, 1'b0, 32'd0);

      // Random ready/redirect traffic
      hs0 = hs_cnt;
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);
      end
      chk("rand_progress", 32'((hs_cnt - hs0) >= 60), 32'd1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0);
      do_reset();
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
